// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram read-out path.
package histogram_pkg;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_COUNT_W = 32;
    localparam int unsigned DEF_CUM_W   = DEF_ADDR_W + DEF_COUNT_W;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } scan_state_e;

endpackage

// File: rtl/histogram_readout.sv
// Scans every histogram bin once per start, streaming bin/count/cumulative-sum
// beats and reporting the total and the peak bin at the end.
module histogram_readout
    import histogram_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned COUNT_W   = DEF_COUNT_W,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [COUNT_W-1:0]         rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_bin,
    output logic [COUNT_W-1:0]         out_count,
    output logic [COUNT_W+ADDR_W-1:0]  out_cum,
    output logic                       out_last,
    output logic [COUNT_W+ADDR_W-1:0]  total,
    output logic [ADDR_W-1:0]          mode_bin,
    output logic [COUNT_W-1:0]         mode_count
);

    localparam int unsigned CUM_W = COUNT_W + ADDR_W;

    scan_state_e state_q, state_d;

    logic [CUM_W-1:0]   cum_q;
    logic [CUM_W-1:0]   cum_sum;
    logic [COUNT_W-1:0] peak_count_q;
    logic [ADDR_W-1:0]  peak_bin_q;

    logic out_free;
    logic last_addr;
    logic emit;
    logic accept;
    logic consume;
    logic finish;

    assign out_free  = !out_valid || out_ready;
    assign last_addr = &rd_addr;
    assign emit      = !(SKIP_ZERO && (rd_data == '0));
    assign cum_sum   = cum_q + CUM_W'(rd_data);

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        consume = 1'b0;
        finish  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (out_free) begin
                    consume = 1'b1;
                    if (last_addr) state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_free) state_d = StDone;
            end
            StDone: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_addr      <= '0;
            cum_q        <= '0;
            peak_count_q <= '0;
            peak_bin_q   <= '0;
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_count    <= '0;
            out_cum      <= '0;
            out_last     <= 1'b0;
            total        <= '0;
            mode_bin     <= '0;
            mode_count   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_addr      <= '0;
                cum_q        <= '0;
                peak_count_q <= '0;
                peak_bin_q   <= '0;
                total        <= '0;
                mode_bin     <= '0;
                mode_count   <= '0;
            end
            if (consume) begin
                rd_addr   <= rd_addr + ADDR_W'(1);
                cum_q     <= cum_sum;
                // Strict compare keeps the lowest index on ties.
                if (rd_data > peak_count_q) begin
                    peak_count_q <= rd_data;
                    peak_bin_q   <= rd_addr;
                end
                out_valid <= emit;
                out_bin   <= rd_addr;
                out_count <= rd_data;
                out_cum   <= cum_sum;
                out_last  <= last_addr && emit;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (finish) begin
                total      <= cum_q;
                mode_bin   <= peak_bin_q;
                mode_count <= peak_count_q;
            end
        end
    end

endmodule

// File: tb/tb_histogram_readout.sv
// Self-checking bench: two instances (SKIP_ZERO off/on) sharing one histogram memory.
module tb_histogram_readout;

    localparam int unsigned AW = 10;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = AW + CW;
    localparam int unsigned NB = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] bin;
        logic [CW-1:0] cnt;
        logic [SW-1:0] cum;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] mem [NB];

    logic          start_s      [2];
    logic          ready_s      [2];
    logic          busy_s       [2];
    logic          done_s       [2];
    logic          valid_s      [2];
    logic          last_s       [2];
    logic [AW-1:0] rd_addr_s    [2];
    logic [AW-1:0] bin_s        [2];
    logic [AW-1:0] mode_bin_s   [2];
    logic [CW-1:0] rd_data_s    [2];
    logic [CW-1:0] count_s      [2];
    logic [CW-1:0] mode_count_s [2];
    logic [SW-1:0] cum_s        [2];
    logic [SW-1:0] total_s      [2];

    int n_checks = 0;
    int n_bad    = 0;

    beat_t         exp_q[$];
    logic [SW-1:0] exp_total;
    logic [AW-1:0] exp_mbin;
    logic [CW-1:0] exp_mcnt;

    always #5 clk = ~clk;

    assign rd_data_s[0] = mem[rd_addr_s[0]];
    assign rd_data_s[1] = mem[rd_addr_s[1]];

    histogram_readout #(.ADDR_W(AW), .COUNT_W(CW), .SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]), .out_valid(valid_s[0]),
        .out_ready(ready_s[0]), .out_bin(bin_s[0]), .out_count(count_s[0]), .out_cum(cum_s[0]),
        .out_last(last_s[0]), .total(total_s[0]), .mode_bin(mode_bin_s[0]),
        .mode_count(mode_count_s[0])
    );

    histogram_readout #(.ADDR_W(AW), .COUNT_W(CW), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1]), .out_valid(valid_s[1]),
        .out_ready(ready_s[1]), .out_bin(bin_s[1]), .out_count(count_s[1]), .out_cum(cum_s[1]),
        .out_last(last_s[1]), .total(total_s[1]), .mode_bin(mode_bin_s[1]),
        .mode_count(mode_count_s[1])
    );

    // Reference: stream contents, total and peak derived directly from the bin array.
    task automatic build_expect(input bit skip);
        logic [SW-1:0] sum;
        exp_q.delete();
        sum      = '0;
        exp_mbin = '0;
        exp_mcnt = '0;
        for (int b = 0; b < NB; b++) begin
            sum = sum + SW'(mem[b]);
            if (mem[b] > exp_mcnt) begin
                exp_mcnt = mem[b];
                exp_mbin = AW'(b);
            end
            if (!(skip && mem[b] == '0))
                exp_q.push_back('{bin: AW'(b), cnt: mem[b], cum: sum, last: (b == NB - 1)});
        end
        exp_total = sum;
    endtask

    task automatic clear_mem();
        for (int b = 0; b < NB; b++) mem[b] = '0;
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        n_checks++;
        if ({busy_s[sel], done_s[sel], valid_s[sel], last_s[sel], rd_addr_s[sel], bin_s[sel],
             count_s[sel], cum_s[sel], total_s[sel], mode_bin_s[sel], mode_count_s[sel]} !== '0) begin
            n_bad++;
            $display("FAIL %s dut%0d: busy=%b done=%b valid=%b last=%b addr=%0d bin=%0d cnt=%0d cum=%0d total=%0d mbin=%0d mcnt=%0d, want all 0",
                     tag, sel, busy_s[sel], done_s[sel], valid_s[sel], last_s[sel], rd_addr_s[sel],
                     bin_s[sel], count_s[sel], cum_s[sel], total_s[sel], mode_bin_s[sel],
                     mode_count_s[sel]);
        end
    endtask

    task automatic run_scan(input int sel, input bit rand_ready, input bit rand_start,
                            input bit check_timing);
        int    k;
        int    first_valid;
        int    done_k;
        bit    got_done;
        bit    stalled;
        bit    r;
        beat_t got_b;
        beat_t prev_b;
        beat_t exp_b;
        logic [AW-1:0] prev_addr;
        build_expect(sel == 1);
        @(negedge clk);
        start_s[sel] = 1'b1;
        ready_s[sel] = 1'b1;
        k = 0; first_valid = -1; done_k = -1; got_done = 1'b0; stalled = 1'b0;
        prev_b = '0; prev_addr = '0;
        while (!got_done && k < 8000) begin
            @(negedge clk);
            k++;
            got_b = '{bin: bin_s[sel], cnt: count_s[sel], cum: cum_s[sel], last: last_s[sel]};
            if (k == 1) begin
                n_checks++;
                if (busy_s[sel] !== 1'b1 || valid_s[sel] !== 1'b0 || rd_addr_s[sel] !== '0 ||
                    total_s[sel] !== '0 || mode_bin_s[sel] !== '0 || mode_count_s[sel] !== '0) begin
                    n_bad++;
                    $display("FAIL start_state dut%0d: busy=%b valid=%b addr=%0d total=%0d mbin=%0d mcnt=%0d, want 1 0 0 0 0 0",
                             sel, busy_s[sel], valid_s[sel], rd_addr_s[sel], total_s[sel],
                             mode_bin_s[sel], mode_count_s[sel]);
                end
            end
            if (valid_s[sel] === 1'b1 && first_valid < 0) first_valid = k;
            if (stalled) begin
                n_checks++;
                if (valid_s[sel] !== 1'b1 || got_b !== prev_b || rd_addr_s[sel] !== prev_addr) begin
                    n_bad++;
                    $display("FAIL stall_hold dut%0d cyc%0d: valid=%b bin=%0d cum=%0d addr=%0d, want 1 bin=%0d cum=%0d addr=%0d",
                             sel, k, valid_s[sel], got_b.bin, got_b.cum, rd_addr_s[sel],
                             prev_b.bin, prev_b.cum, prev_addr);
                end
            end
            if (done_s[sel] === 1'b1) begin
                got_done = 1'b1;
                done_k   = k;
            end
            r = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            ready_s[sel] = r;
            start_s[sel] = rand_start ? ($urandom_range(0, 15) == 0) : 1'b0;
            if (valid_s[sel] === 1'b1 && r) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat dut%0d: got bin=%0d cnt=%0d, want no beat",
                             sel, got_b.bin, got_b.cnt);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        n_bad++;
                        $display("FAIL beat dut%0d: got bin=%0d cnt=%0d cum=%0d last=%b, want bin=%0d cnt=%0d cum=%0d last=%b",
                                 sel, got_b.bin, got_b.cnt, got_b.cum, got_b.last,
                                 exp_b.bin, exp_b.cnt, exp_b.cum, exp_b.last);
                    end
                end
            end
            stalled   = (valid_s[sel] === 1'b1) && !r;
            prev_b    = got_b;
            prev_addr = rd_addr_s[sel];
        end
        n_checks++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL done_timeout dut%0d: got no done in %0d cycles, want done", sel, k);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_beats dut%0d: got %0d beats short, want 0", sel, exp_q.size());
        end
        if (check_timing) begin
            n_checks++;
            if (first_valid != 2 || done_k != NB + 2) begin
                n_bad++;
                $display("FAIL latency dut%0d: got first_valid=t+%0d done=t+%0d, want t+2 and t+%0d",
                         sel, first_valid, done_k, NB + 2);
            end
        end
        // One cycle after done: idle, no second done, results held.
        @(negedge clk);
        start_s[sel] = 1'b0;
        ready_s[sel] = 1'b1;
        n_checks++;
        if (busy_s[sel] !== 1'b0 || done_s[sel] !== 1'b0 || valid_s[sel] !== 1'b0 ||
            total_s[sel] !== exp_total || mode_bin_s[sel] !== exp_mbin ||
            mode_count_s[sel] !== exp_mcnt) begin
            n_bad++;
            $display("FAIL result dut%0d: busy=%b done=%b valid=%b total=%0d mbin=%0d mcnt=%0d, want 0 0 0 total=%0d mbin=%0d mcnt=%0d",
                     sel, busy_s[sel], done_s[sel], valid_s[sel], total_s[sel], mode_bin_s[sel],
                     mode_count_s[sel], exp_total, exp_mbin, exp_mcnt);
        end
    endtask

    task automatic check_results(input int sel, input logic [SW-1:0] t, input logic [AW-1:0] mb,
                                 input logic [CW-1:0] mc, input string tag);
        n_checks++;
        if (total_s[sel] !== t || mode_bin_s[sel] !== mb || mode_count_s[sel] !== mc) begin
            n_bad++;
            $display("FAIL %s dut%0d: total=%0d mbin=%0d mcnt=%0d, want %0d %0d %0d",
                     tag, sel, total_s[sel], mode_bin_s[sel], mode_count_s[sel], t, mb, mc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero(0, "reset");
        check_all_zero(1, "reset");
        rst = 1'b0;
    endtask

    task automatic test_preload();
        clear_mem();
        mem[3] = 5; mem[7] = 2; mem[NB-1] = 1;
        run_scan(0, 1'b0, 1'b0, 1'b1);
        check_results(0, 8, 3, 5, "preload_results");
        run_scan(1, 1'b0, 1'b0, 1'b0);
        check_results(1, 8, 3, 5, "preload_skip_results");
    endtask

    task automatic test_tie();
        clear_mem();
        mem[10] = 9; mem[20] = 9;
        run_scan(0, 1'b0, 1'b0, 1'b0);
        check_results(0, 18, 10, 9, "tie_results");
    endtask

    task automatic test_random_stall();
        for (int b = 0; b < NB; b++)
            mem[b] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
        run_scan(0, 1'b1, 1'b1, 1'b0);
        run_scan(1, 1'b1, 1'b1, 1'b0);
        run_scan(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        clear_mem();
        run_scan(0, 1'b0, 1'b0, 1'b1);
        check_results(0, 0, 0, 0, "empty_results");
        run_scan(1, 1'b1, 1'b0, 1'b0);
        check_results(1, 0, 0, 0, "empty_skip_results");
    endtask

    task automatic test_reset_mid_scan();
        int k;
        for (int b = 0; b < NB; b++) mem[b] = $urandom_range(1, 1000);
        @(negedge clk);
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start_s[0] = 1'b0;
            k++;
        end while (rd_addr_s[0] != AW'(500) && k < 2000);
        n_checks++;
        if (rd_addr_s[0] !== AW'(500) || busy_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_scan_reach: addr=%0d busy=%b, want addr=500 busy=1",
                     rd_addr_s[0], busy_s[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero(0, "mid_scan_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle: done=%b busy=%b, want 0 0", done_s[0], busy_s[0]);
            end
        end
        run_scan(0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < NB; b++) mem[b] = $urandom_range(0, 50);
        run_scan(0, 1'b0, 1'b0, 1'b1);
        run_scan(0, 1'b1, 1'b0, 1'b0);
        run_scan(1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            ready_s[s] = 1'b1;
        end
        clear_mem();
        test_reset();
        test_preload();
        test_tie();
        test_random_stall();
        test_empty();
        test_reset_mid_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/histogram_readout.md
Name: histogram_readout

Overview:
- Reader side of the RR-interval probability-distribution histogram.
- On a start pulse, it walks every bin address from 0 to NUM_BINS-1 and samples each bin count. Each bin is streamed out over a valid/ready interface with a running cumulative sum.
- At the end of the scan it reports the total sample count and the mode (peak bin).
- Sits between the histogram memory's read port and downstream CDF/statistics or host-upload logic.

Parameters:
- ADDR_W, 10, bin address width; NUM_BINS = 2**ADDR_W.
- COUNT_W, 32, width of one bin count.
- SKIP_ZERO, 0, when 1, bins with count 0 are scanned but not emitted on the stream.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan is complete.
- rd_addr  out  ADDR_W  bin index presented to the histogram read port (registered).
- rd_data  in  COUNT_W  bin count; valid combinationally for the current rd_addr.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_bin  out  ADDR_W  bin index of the beat.
- out_count  out  COUNT_W  count of that bin.
- out_cum  out  COUNT_W+ADDR_W  inclusive cumulative sum of counts, bins 0..out_bin.
- out_last  out  1  beat carries bin NUM_BINS-1.
- total  out  COUNT_W+ADDR_W  sum of all bins; valid from done until the next start.
- mode_bin  out  ADDR_W  index of the largest count; ties resolve to the lowest index.
- mode_count  out  COUNT_W  largest count.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-scan aborts the scan:
  - any pending beat is dropped;
  - no done pulse is produced;
  - accumulators are cleared.
- FSM states:
  - IDLE: on start, clear cum/mode accumulators, set rd_addr=0, go to SCAN.
  - SCAN: a bin is consumed in any cycle where the output register is free (!out_valid or out_ready).
    - Capture rd_data into out_count/out_bin.
    - Update cum = cum + rd_data; out_cum gets the updated value.
    - If rd_data > mode_count, set mode_count=rd_data and mode_bin=rd_addr.
    - Increment rd_addr.
    - After consuming bin NUM_BINS-1, go to DRAIN.
  - DRAIN: wait until the output register is empty or the pending beat is accepted, then go to DONE.
  - DONE: pulse done for 1 cycle, latch total=cum, go to IDLE.
- busy is high in SCAN, DRAIN and DONE.
- Latency and throughput:
  - start sampled at edge t: rd_addr=0 during cycle t+1, first out_valid in cycle t+2.
  - With out_ready held high, throughput is 1 bin/cycle.
  - For SKIP_ZERO=0, done pulses in cycle t+NUM_BINS+2.
- Backpressure:
  - While out_valid && !out_ready, rd_addr and all out_* signals hold stable.
  - out_valid never deasserts without a handshake.
- SKIP_ZERO=1:
  - A zero bin still advances rd_addr and is still included in the cum/mode logic (no effect on either).
  - No beat is emitted for a zero bin, so the bin consumes one cycle.
  - out_last appears only if bin NUM_BINS-1 is nonzero; done always pulses.
- Arithmetic: cum width COUNT_W+ADDR_W, so it cannot overflow for NUM_BINS full-scale bins.
- Empty histogram: total=0, mode_bin=0, mode_count=0.
- start asserted in the DONE cycle is ignored; start in IDLE is accepted.
- total, mode_bin and mode_count hold their values from done until the next accepted start, then read 0 until the next done.
- Read-port contract: the histogram must not be updated for the duration of the scan. Concurrent writes give undefined results, which is out of scope for this block.

Decomposition:
- Shared package histogram_pkg:
  - ADDR_W and COUNT_W defaults;
  - CUM_W = COUNT_W+ADDR_W;
  - FSM state enum {IDLE, SCAN, DRAIN, DONE}.
- No sub-module is required. The single-entry output register with its valid/ready hold logic may be factored as stream_out_reg if reused elsewhere.

Test Plan:
- Preload bins 3=5, 7=2, 1023=1 (rest 0), SKIP_ZERO=0, out_ready=1, start -> 1024 beats:
  - bin 3 beat has out_cum=5; bin 7 beat has out_cum=7; bin 1023 beat has out_last=1 and out_cum=8;
  - done at t+1026 with total=8, mode_bin=3, mode_count=5.
- Same preload, SKIP_ZERO=1 -> exactly 3 beats (bins 3, 7, 1023), last with out_last=1; done pulses; total=8.
- Tie: bins 10=9 and 20=9 -> mode_bin=10, mode_count=9.
- out_ready toggled randomly -> every bin emitted once, in order, with out_* stable while stalled; count and cum sequence identical to the no-stall run.
- All-zero histogram -> total=0, mode_bin=0, mode_count=0; with SKIP_ZERO=1, no beats and done still pulses.
- Assert rst during bin 500 -> next cycle all outputs 0, no done. A fresh start then produces a full correct scan. start pulses while busy are ignored (one done per accepted start).
